// File: rtl/fifo8.sv
// fifo8: 8-word x 16-bit first-word-fall-through FIFO with valid/ready on both sides,
// an almost_full threshold and a sticky overflow flag.
module fifo8 #(
  parameter int AF_LEVEL = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  count,
  output logic        almost_full,
  output logic        overflow
);

  // Handshake: a word moves on a side only in a cycle where valid && ready is
  // high at the rising edge; ready and valid come only from registered count.

  logic [15:0] mem_q [8];
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        push, pop;

  assign in_ready    = (count_q != 4'd8);
  assign out_valid   = (count_q != 4'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign count       = count_q;
  assign almost_full = (count_q >= 4'(AF_LEVEL));
  assign overflow    = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 3'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 3'd1;
    if (push && !pop) count_d = count_q + 4'd1;
    if (pop && !push) count_d = count_q - 4'd1;
    if (in_valid && !in_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= 3'd0;
      rd_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; out_data masks it whenever count is 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_fifo8.sv
// Self-checking bench for fifo8: a reference queue model predicts every output
// and the popped data stream.
module tb_fifo8;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;

  fifo8 #(.AF_LEVEL(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        ovf_m;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One cycle: drive at negedge, compare against the model, advance model, wait to next negedge.
  task automatic step(input logic iv, input logic [15:0] d, input logic ordy);
    logic        m_ready;
    logic        m_valid;
    logic [15:0] head;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    m_ready = (exp_q.size() != 8);
    m_valid = (exp_q.size() != 0);
    check("count", 32'(count), 32'(exp_q.size()));
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("almost_full", 32'(almost_full), 32'(exp_q.size() >= 6));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (!m_valid) check("out_data_empty", 32'(out_data), 32'h0);
    if (ordy && m_valid) begin
      head = exp_q.pop_front();
      check("pop_data", 32'(out_data), 32'(head));
    end
    if (iv && m_ready) exp_q.push_back(d);
    if (iv && !m_ready) ovf_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) step(1'b0, 16'(i * 16'h0101), 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    n_fail    = 0;
    ovf_m     = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Outputs held while reset is low
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_almost_full", 32'(almost_full), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 16'($urandom_range(0, 16'hffff)), 1'b0);

    // Three words in, then three out
    step(1'b1, 16'h1111, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    step(1'b1, 16'h3333, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) step(1'b1, 16'hA0 + 16'(i), 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    drain();

    // Wrap-around
    for (int i = 0; i < 5; i++) step(1'b1, 16'hC0 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 16'hB0 + 16'(i), 1'b0);
    drain();

    // Streaming at count = 2
    step(1'b1, 16'h5001, 1'b0);
    step(1'b1, 16'h5002, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom_range(0, 16'hffff)), 1'b1);
    drain();

    // Random mixed traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 16'hffff)), 1'($urandom_range(0, 1)));

    // Mid-operation asynchronous reset with five words queued
    drain();
    for (int i = 0; i < 5; i++) step(1'b1, 16'hD0 + 16'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'h0);
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_out_data", 32'(out_data), 32'h0);
    check("async_rst_overflow", 32'(overflow), 32'h0);
    exp_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h7777, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h7777);
    check("post_rst_count", 32'(count), 32'h1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
